// File: rtl/stage_reg_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// inReady comes from registered state only, so there is no combinational path from outReady.
module stage_reg_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [CNT_W-1:0] stallCount
);

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_s_data;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_accept;
  logic w_m_free;
  logic w_stall;

  assign inReady    = rst_n & ~r_s_valid;
  assign outValid   = r_m_valid;
  assign outData    = r_m_data;
  assign stallCount = r_stall_cnt;

  assign w_accept = inValid & inReady;
  assign w_m_free = ~r_m_valid | outReady;
  assign w_stall  = r_m_valid & ~outReady;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid   <= 1'b0;
      r_m_data    <= BUBBLE;
      r_s_valid   <= 1'b0;
      r_s_data    <= '0;
      r_stall_cnt <= '0;
    end else begin
      // The stall counter runs even on a flush cycle.
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      if (flush) begin
        r_m_valid <= 1'b0;
        r_m_data  <= BUBBLE;
        r_s_valid <= 1'b0;
      end else if (w_m_free) begin
        if (r_s_valid) begin
          r_m_valid <= 1'b1;
          r_m_data  <= r_s_data;
          r_s_valid <= 1'b0;
        end else if (w_accept) begin
          r_m_valid <= 1'b1;
          r_m_data  <= inData;
        end else begin
          r_m_valid <= 1'b0;
          r_m_data  <= BUBBLE;
        end
      end else if (w_accept) begin
        r_s_valid <= 1'b1;
        r_s_data  <= inData;
      end
    end
  end

endmodule

// File: tb/tb_stage_reg_skid.sv
// Bench for stage_reg_skid: a queue model of the stored entries predicts every output;
// bundles are pushed on accept and popped and compared on emit.
module tb_stage_reg_skid;
  localparam int          WIDTH   = 32;
  localparam logic [31:0] BUBBLE  = 32'hDEAD_BEEF;
  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;
  logic [CNT_W-1:0] stallCount;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q[$];
  int          cnt      = 0;
  logic [31:0] nxt      = 32'd1;

  stage_reg_skid #(.WIDTH(WIDTH), .BUBBLE(BUBBLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .inData    (inData),
    .inValid   (inValid),
    .inReady   (inReady),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .stallCount(stallCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare outputs to the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy,
                      input bit en = 1'b1);
    logic rdy;
    logic stl;
    rst_n    = rst;
    flush    = fl;
    inValid  = iv;
    inData   = nxt;
    outReady = ordy;
    #1;
    rdy = rst && (q.size() < 2);
    stl = (q.size() > 0) && !ordy;
    chk_eq("inReady", inReady, rdy);
    if (en) begin
      chk_eq("outValid", outValid, q.size() > 0);
      chk_eq("stallCount", stallCount, cnt);
      if ((q.size() > 0) && rst && !fl && ordy)
        chk_eq("emit", outData, q.pop_front());
      else
        chk_eq("outData", outData, (q.size() > 0) ? q[0] : BUBBLE);
    end
    @(posedge clk);
    if (!rst) begin
      q.delete();
      cnt = 0;
    end else begin
      if (stl && cnt != CNT_MAX) cnt++;
      if (fl) q.delete();
      else if (iv && rdy) begin
        q.push_back(nxt);
        nxt++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // reset then stream
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    chk_eq("stream_cnt0", stallCount, 0);

    // skid fill and drain
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_eq("skid_stall3", stallCount, 3);
    chk_eq("skid_ready_low", inReady, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

    // flush with a full stage and a simultaneous offer
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_eq("full_before_flush", inReady, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_eq("flush_valid", outValid, 1'b0);
    chk_eq("flush_bubble", outData, BUBBLE);
    chk_eq("flush_ready", inReady, 1'b1);
    chk_eq("flush_cnt", stallCount, 6);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // saturation
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_eq("sat15", stallCount, 15);

    // flush and reset together
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_eq("rst_flush_cnt", stallCount, 0);
    chk_eq("rst_flush_valid", outValid, 1'b0);
    chk_eq("rst_flush_data", outData, BUBBLE);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step(1'b1, ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk_eq("drain_bubble", outData, BUBBLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
